// File: rtl/dpu_render_pkg.sv
// Shared VGA timing, palette, geometry and snapshot types for the DPU pixel renderer.
package dpu_render_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned POS_W = 11;
   localparam int unsigned BND_W = 12;
   localparam int unsigned HP_W  = 4;
   localparam int unsigned RGB_W = 8;

   localparam int unsigned SPRITE_W  = 32;
   localparam int unsigned SPRITE_H  = 64;
   localparam int unsigned FACE_ROW0 = 8;
   localparam int unsigned FACE_ROW1 = 16;
   localparam int unsigned FACE_COLS = 4;
   localparam int unsigned HB_X0     = 16;
   localparam int unsigned HB_X1     = 624;
   localparam int unsigned HB_Y0     = 16;
   localparam int unsigned HB_Y1     = 24;
   localparam int unsigned HB_STEP   = 16;
   localparam int unsigned GROUND_Y  = 448;

   typedef enum logic [2:0] {
      GS_TITLE   = 3'd0,
      GS_FIGHT   = 3'd1,
      GS_PAUSED  = 3'd2,
      GS_P1_WINS = 3'd3,
      GS_P2_WINS = 3'd4
   } game_state_e;

   typedef enum logic [1:0] {
      PS_IDLE   = 2'd0,
      PS_ATTACK = 2'd1,
      PS_BLOCK  = 2'd2,
      PS_HURT   = 2'd3
   } player_state_e;

   typedef logic [RGB_W-1:0] rgb_t;

   localparam rgb_t C_OFF       = 8'h00;
   localparam rgb_t C_TITLE     = 8'h25;
   localparam rgb_t C_P1_WINS   = 8'hE0;
   localparam rgb_t C_P2_WINS   = 8'h03;
   localparam rgb_t C_HEALTH    = 8'h1C;
   localparam rgb_t C_FACE      = 8'h00;
   localparam rgb_t C_P1_IDLE   = 8'hE0;
   localparam rgb_t C_P2_IDLE   = 8'h03;
   localparam rgb_t C_ATTACK    = 8'hFC;
   localparam rgb_t C_BLOCK     = 8'h92;
   localparam rgb_t C_HURT      = 8'hFF;
   localparam rgb_t C_GROUND    = 8'h8C;
   localparam rgb_t C_BG        = 8'h49;
   localparam rgb_t C_BG_PAUSED = 8'h24;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      player_state_e    st;
      logic             left;
      logic [HP_W-1:0]  health;
   } player_snap_t;

   typedef struct packed {
      game_state_e  gs;
      player_snap_t p1;
      player_snap_t p2;
   } game_snap_t;

   // Returns {hit, colour} for one player rectangle at raster position (h,v).
   function automatic logic [RGB_W:0] sprite_px(input logic [BND_W-1:0] h,
                                                input logic [BND_W-1:0] v,
                                                input player_snap_t p,
                                                input rgb_t idle_c);
      logic [BND_W-1:0] px, py, dx, dy;
      logic hit, face;
      rgb_t c;
      px   = BND_W'(p.x);
      py   = BND_W'(p.y);
      dx   = h - px;
      dy   = v - py;
      hit  = (h >= px) && (h < px + BND_W'(SPRITE_W)) &&
             (v >= py) && (v < py + BND_W'(SPRITE_H));
      face = (dy >= BND_W'(FACE_ROW0)) && (dy < BND_W'(FACE_ROW1)) &&
             (p.left ? (dx < BND_W'(FACE_COLS)) : (dx >= BND_W'(SPRITE_W - FACE_COLS)));
      case (p.st)
         PS_IDLE:   c = idle_c;
         PS_ATTACK: c = C_ATTACK;
         PS_BLOCK:  c = C_BLOCK;
         default:   c = C_HURT;
      endcase
      if (face) c = C_FACE;
      return {hit, c};
   endfunction

endpackage

// File: rtl/dpu_frame_renderer_if.sv
// Game-state inputs and VGA pixel outputs of the frame renderer.
interface dpu_frame_renderer_if;
   logic                               pix_ce;
   logic [2:0]                         gameState;
   logic [1:0]                         p1State, p2State;
   logic [dpu_render_pkg::HP_W-1:0]    p1health, p2health;
   logic [dpu_render_pkg::POS_W-1:0]   x1, y1, x2, y2;
   logic                               p1Left, p2Left;
   logic                               hsync, vsync, de, frame_start;
   logic [dpu_render_pkg::RGB_W-1:0]   rgb;
   logic [dpu_render_pkg::CNT_W-1:0]   hcount, vcount;

   modport slave (
      input  pix_ce, gameState, p1State, p2State, p1health, p2health,
             x1, y1, x2, y2, p1Left, p2Left,
      output hsync, vsync, de, rgb, hcount, vcount, frame_start
   );

   modport master (
      output pix_ce, gameState, p1State, p2State, p1health, p2health,
             x1, y1, x2, y2, p1Left, p2Left,
      input  hsync, vsync, de, rgb, hcount, vcount, frame_start
   );
endinterface

// File: rtl/vga_timing.sv
// 640x480 raster counters with sync/data-enable decode and end-of-frame strobe.
module vga_timing
   import dpu_render_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_ce_i,
   output logic [CNT_W-1:0] hcount_o,
   output logic [CNT_W-1:0] vcount_o,
   output logic             hsync_c_o,
   output logic             vsync_c_o,
   output logic             de_c_o,
   output logic             eof_c_o
);
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             h_last, v_last;

   always_comb begin
      h_last = (h_q == CNT_W'(H_TOTAL - 1));
      v_last = (v_q == CNT_W'(V_TOTAL - 1));
      h_d    = h_q;
      v_d    = v_q;
      if (pix_ce_i) begin
         h_d = h_last ? '0 : h_q + CNT_W'(1);
         if (h_last) v_d = v_last ? '0 : v_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Decode describes the current counter position; the top registers it.
   assign hsync_c_o = !((h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
   assign vsync_c_o = !((v_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (v_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
   assign de_c_o    = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
   assign eof_c_o   = pix_ce_i && h_last && v_last;
   assign hcount_o  = h_q;
   assign vcount_o  = v_q;
endmodule

// File: rtl/dpu_frame_renderer.sv
// Per-frame game-state snapshot, colour selection and registered RGB332/sync output.
module dpu_frame_renderer
   import dpu_render_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   dpu_frame_renderer_if.slave bus
);
   logic [CNT_W-1:0] hcount, vcount;
   logic             hsync_c, vsync_c, de_c, eof_c;
   game_snap_t       snap_d, snap_q;
   logic             hsync_q, vsync_q, de_q, frame_start_q;
   rgb_t             rgb_q, colour_c;
   logic [BND_W-1:0] h_c, v_c, p1_bar_end_c, p2_bar_start_c;
   logic [RGB_W:0]   p1_px_c, p2_px_c;
   logic             bar_c;

   vga_timing u_timing (
      .clk       (clk),
      .rst       (rst),
      .pix_ce_i  (bus.pix_ce),
      .hcount_o  (hcount),
      .vcount_o  (vcount),
      .hsync_c_o (hsync_c),
      .vsync_c_o (vsync_c),
      .de_c_o    (de_c),
      .eof_c_o   (eof_c)
   );

   always_comb begin
      snap_d           = '0;
      snap_d.gs        = game_state_e'(bus.gameState);
      snap_d.p1.x      = bus.x1;
      snap_d.p1.y      = bus.y1;
      snap_d.p1.st     = player_state_e'(bus.p1State);
      snap_d.p1.left   = bus.p1Left;
      snap_d.p1.health = bus.p1health;
      snap_d.p2.x      = bus.x2;
      snap_d.p2.y      = bus.y2;
      snap_d.p2.st     = player_state_e'(bus.p2State);
      snap_d.p2.left   = bus.p2Left;
      snap_d.p2.health = bus.p2health;
   end

   // Layer priority: health bars, P1, P2, ground, background.
   always_comb begin
      h_c            = BND_W'(hcount);
      v_c            = BND_W'(vcount);
      p1_px_c        = sprite_px(h_c, v_c, snap_q.p1, C_P1_IDLE);
      p2_px_c        = sprite_px(h_c, v_c, snap_q.p2, C_P2_IDLE);
      p1_bar_end_c   = BND_W'(HB_X0) + BND_W'(snap_q.p1.health) * BND_W'(HB_STEP);
      p2_bar_start_c = BND_W'(HB_X1) - BND_W'(snap_q.p2.health) * BND_W'(HB_STEP);
      bar_c          = (v_c >= BND_W'(HB_Y0)) && (v_c < BND_W'(HB_Y1)) &&
                       (((h_c >= BND_W'(HB_X0)) && (h_c < p1_bar_end_c)) ||
                        ((h_c >= p2_bar_start_c) && (h_c < BND_W'(HB_X1))));
      colour_c       = C_OFF;
      case (snap_q.gs)
         GS_TITLE:   colour_c = C_TITLE;
         GS_P1_WINS: colour_c = C_P1_WINS;
         GS_P2_WINS: colour_c = C_P2_WINS;
         GS_FIGHT, GS_PAUSED: begin
            if (bar_c)                          colour_c = C_HEALTH;
            else if (p1_px_c[RGB_W])            colour_c = p1_px_c[RGB_W-1:0];
            else if (p2_px_c[RGB_W])            colour_c = p2_px_c[RGB_W-1:0];
            else if (v_c >= BND_W'(GROUND_Y))   colour_c = C_GROUND;
            else if (snap_q.gs == GS_PAUSED)    colour_c = C_BG_PAUSED;
            else                                colour_c = C_BG;
         end
         default:    colour_c = C_OFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q        <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= eof_c;
         if (eof_c) snap_q <= snap_d;
         if (bus.pix_ce) begin
            hsync_q <= hsync_c;
            vsync_q <= vsync_c;
            de_q    <= de_c;
            rgb_q   <= de_c ? colour_c : C_OFF;
         end
      end
   end

   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.de          = de_q;
   assign bus.rgb         = rgb_q;
   assign bus.hcount      = hcount;
   assign bus.vcount      = vcount;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_dpu_frame_renderer.sv
// Directed bench for dpu_frame_renderer: raster timing, snapshot behaviour, colour layers, reset.
module tb_dpu_frame_renderer;
   import dpu_render_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   dpu_frame_renderer_if bus ();

   dpu_frame_renderer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic goto_px(input string tag, input int h, input int v);
      int n;
      n = 0;
      while (!(int'(bus.hcount) == h && int'(bus.vcount) == v) && n < 450000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_reached"}, 32'(n < 450000), 32'd1);
   endtask

   task automatic chk_px(input string tag, input int h, input int v, input logic [7:0] exp);
      goto_px(tag, h, v);
      step();
      chk(tag, 32'(bus.rgb), 32'(exp));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_hcount"}, 32'(bus.hcount), 32'd0);
      chk({tag, "_vcount"}, 32'(bus.vcount), 32'd0);
      chk({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
      chk({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
      chk({tag, "_de"}, 32'(bus.de), 32'd0);
      chk({tag, "_rgb"}, 32'(bus.rgb), 32'd0);
      chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
   endtask

   initial begin
      int p, ph, pv, n;
      int cnt_err, hs_err, vs_err, de_err, rgb_err, fs_err;
      int hs_low, vs_low, de_hi, fs_cnt, px_err, vis;
      logic exp_de;
      logic [7:0] exp_rgb;
      logic [30:0] prev;

      rst = 1'b1;
      bus.pix_ce = 1'b0;
      bus.gameState = 3'd0;
      bus.p1State = 2'd0;  bus.p2State = 2'd0;
      bus.p1health = 4'd0; bus.p2health = 4'd0;
      bus.x1 = 11'd0; bus.y1 = 11'd0; bus.x2 = 11'd0; bus.y2 = 11'd0;
      bus.p1Left = 1'b0; bus.p2Left = 1'b0;
      repeat (3) step();
      chk_reset_state("reset");

      // Fight scene programmed now; it must only appear after the next snapshot.
      bus.gameState = 3'd1;
      bus.x1 = 11'd100; bus.y1 = 11'd200; bus.p1State = 2'd0; bus.p1Left = 1'b0;
      bus.x2 = 11'd500; bus.y2 = 11'd300; bus.p2State = 2'd2; bus.p2Left = 1'b1;
      bus.p1health = 4'd3; bus.p2health = 4'd15;
      rst = 1'b0;
      bus.pix_ce = 1'b1;

      cnt_err = 0; hs_err = 0; vs_err = 0; de_err = 0; rgb_err = 0; fs_err = 0;
      hs_low = 0; vs_low = 0; de_hi = 0; fs_cnt = 0;
      for (int k = 1; k <= 420000; k++) begin
         step();
         p  = k - 1;
         ph = p % 800;
         pv = p / 800;
         exp_de = (ph < 640) && (pv < 480);
         if (bus.de !== exp_de) de_err++;
         if (bus.hsync !== !(ph >= 656 && ph < 752)) hs_err++;
         if (bus.vsync !== !(pv >= 490 && pv < 492)) vs_err++;
         if (bus.rgb !== (exp_de ? 8'h25 : 8'h00)) rgb_err++;
         if (int'(bus.hcount) != k % 800 || int'(bus.vcount) != (k / 800) % 525) cnt_err++;
         if (bus.frame_start !== (k == 420000)) fs_err++;
         if (!bus.hsync) hs_low++;
         if (!bus.vsync) vs_low++;
         if (bus.de) de_hi++;
         if (bus.frame_start) fs_cnt++;
      end
      chk("f0_counter_model", 32'(cnt_err), 32'd0);
      chk("f0_hsync_position", 32'(hs_err), 32'd0);
      chk("f0_vsync_position", 32'(vs_err), 32'd0);
      chk("f0_de_position", 32'(de_err), 32'd0);
      chk("f0_title_rgb", 32'(rgb_err), 32'd0);
      chk("f0_frame_start_timing", 32'(fs_err), 32'd0);
      chk("f0_hsync_low_ticks", 32'(hs_low), 32'd50400);
      chk("f0_vsync_low_ticks", 32'(vs_low), 32'd1600);
      chk("f0_de_high_ticks", 32'(de_hi), 32'd307200);
      chk("f0_frame_start_count", 32'(fs_cnt), 32'd1);

      // Frame 1: health bars, both sprites, ground.
      chk_px("f1_p1bar_h63", 63, 20, 8'h1C);
      chk_px("f1_p1bar_h64", 64, 20, 8'h49);
      chk_px("f1_p2bar_h383", 383, 20, 8'h49);
      chk_px("f1_p2bar_h384", 384, 20, 8'h1C);
      chk_px("f1_p1_corner", 100, 200, 8'hE0);
      chk_px("f1_p1_right_edge_out", 132, 200, 8'h49);
      chk_px("f1_p1_face", 130, 210, 8'h00);
      goto_px("f1_mid", 0, 240);
      bus.x1 = 11'd300;
      chk_px("f1_p1_old_pos_after_write", 100, 250, 8'hE0);
      chk_px("f1_p1_new_pos_not_yet", 300, 250, 8'h49);
      chk_px("f1_p2_block", 510, 300, 8'h92);
      chk_px("f1_p2_face_left", 500, 308, 8'h00);
      chk_px("f1_ground", 10, 450, 8'h8C);

      goto_px("f1_eof", 799, 524);
      step();
      chk("f1_frame_start", 32'(bus.frame_start), 32'd1);
      chk("f2_start_hcount", 32'(bus.hcount), 32'd0);
      chk("f2_start_vcount", 32'(bus.vcount), 32'd0);

      // Frame 2: sprite moved.
      chk_px("f2_p1_old_pos", 100, 200, 8'h49);
      chk_px("f2_p1_new_pos", 300, 200, 8'hE0);
      chk_px("f2_p1_new_face", 330, 210, 8'h00);

      // Change made on the snapshot cycle itself is captured.
      goto_px("f2_eof", 799, 524);
      bus.gameState = 3'd4;
      step();
      chk("f2_frame_start", 32'(bus.frame_start), 32'd1);

      // Frame 3: P2 wins screen for the first 100 lines.
      n = 0; px_err = 0; vis = 0;
      while (!(int'(bus.vcount) == 100) && n < 100000) begin
         ph = int'(bus.hcount);
         pv = int'(bus.vcount);
         step();
         n++;
         exp_de  = (ph < 640) && (pv < 480);
         exp_rgb = exp_de ? 8'h03 : 8'h00;
         if (exp_de) vis++;
         if (bus.rgb !== exp_rgb) px_err++;
      end
      chk("f3_reach_line100", 32'(n < 100000), 32'd1);
      chk("f3_p2wins_pixels", 32'(px_err), 32'd0);
      chk("f3_visible_count", 32'(vis), 32'd64000);

      rst = 1'b1;
      step();
      chk_reset_state("midreset");
      rst = 1'b0;

      // Pixel tick every third clock after the mid-frame reset.
      px_err = 0;
      for (int c = 0; c < 2400; c++) begin
         bus.pix_ce = (c % 3 == 0);
         prev = {bus.hcount, bus.vcount, bus.hsync, bus.vsync, bus.de, bus.rgb};
         step();
         if (!bus.pix_ce && {bus.hcount, bus.vcount, bus.hsync, bus.vsync, bus.de, bus.rgb} !== prev)
            px_err++;
         if (c == 0) chk("div_first_px_title", 32'(bus.rgb), 32'h25);
         if (c == 2396) begin
            chk("div_hcount_799", 32'(bus.hcount), 32'd799);
            chk("div_vcount_0", 32'(bus.vcount), 32'd0);
         end
         if (c == 2397) begin
            chk("div_hcount_wrap", 32'(bus.hcount), 32'd0);
            chk("div_vcount_1", 32'(bus.vcount), 32'd1);
         end
      end
      chk("div_hold_while_idle", 32'(px_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dpu_frame_renderer.md
# dpu_frame_renderer

Pixel-stage renderer downstream of the DPU MMIO register block. Consumes the latched game state, player states, health and positions, generates 640×480 VGA timing, and emits one RGB332 pixel per pixel tick. All game inputs are snapshotted once per frame, so CPU writes arriving mid-frame never tear the image.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SPRITE_W / SPRITE_H, 32 / 64, player rectangle size in pixels
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pix_ce  in  1  pixel tick; all counters and outputs advance only when high
- gameState  in  3  0 title, 1 fight, 2 paused, 3 p1 wins, 4 p2 wins, 5–7 reserved
- p1State, p2State  in  2  0 idle, 1 attack, 2 block, 3 hurt
- p1health, p2health  in  4  health, 0–15
- x1, y1, x2, y2  in  11  player top-left corner, screen pixels
- p1Left, p2Left  in  1  facing direction, 1 = left
- hsync, vsync  out  1  active-low syncs
- de  out  1  data enable, high in the visible area
- rgb  out  8  RGB332 pixel; 0 when de = 0
- hcount, vcount  out  10  current raster counters
- frame_start  out  1  one-clk pulse when the snapshot is taken

## Operation
- Counters: hcount 0..799, then wraps to 0 and increments vcount; vcount 0..524, then wraps to 0. Both advance only on pix_ce.
- hsync is low for hcount in [656,752). vsync is low for vcount in [490,492). de is high for hcount<640 and vcount<480.
- Snapshot: on a pix_ce cycle with hcount=799 and vcount=524, all game inputs are copied into shadow registers and frame_start pulses. Rendering reads only the shadows.
- Colour selection for a visible pixel (h,v), by gameState:
  - 0: 8'h25.
  - 3: 8'hE0.
  - 4: 8'h03.
  - 5–7: 8'h00.
  - 1 or 2, first match wins:
    1. Health bar, v∈[16,24). P1 covers h∈[16,16+16·p1health). P2 covers h∈[624−16·p2health,624). Colour 8'h1C.
    2. P1 rectangle, h∈[x1,x1+SPRITE_W) and v∈[y1,y1+SPRITE_H). Face marker: rows 8..15 of the sprite, the 4 columns on the facing edge, colour 8'h00. Otherwise the state colour: idle 8'hE0, attack 8'hFC, block 8'h92, hurt 8'hFF.
    3. P2 rectangle, same rules. Idle colour is 8'h03.
    4. Ground, v≥448: 8'h8C.
    5. Background: 8'h49. In state 2 (paused) the background is 8'h24 instead.
- Rectangle bounds are computed 12 bits wide, so x+SPRITE_W never wraps. Off-screen parts are clipped naturally by de. A health value of 0 draws no bar.

## Timing
- Reset values:
  - hcount=0, vcount=0.
  - hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
  - All shadows 0, so the first frame renders as title.
- hsync, vsync, de and rgb are registered together. They describe the counter position of the previous pix_ce tick (latency 1 tick) and stay mutually aligned.
- Outputs hold their values while pix_ce=0.
- Input changes take effect only from the next snapshot, i.e. the following frame. A change on the snapshot cycle itself is captured.
- Reset mid-frame: counters restart at 0,0, shadows clear, outputs return to reset values on the next clock.

## Structure
- Package dpu_render_pkg holds:
  - timing constants and H_TOTAL=800 / V_TOTAL=525;
  - the game-state enum and player-state enum;
  - all colour constants;
  - the health bar geometry (x 16/624, y 16..23, 16 px per health point).
- Sub-module vga_timing: the counters, sync/de generation and the end-of-frame strobe.
- The top module holds the shadow registers, the colour mux and the output register.

## Test plan
- Reset, then 800×525 pix_ce ticks. Expect:
  - hsync low for exactly 96 ticks per line;
  - vsync low for exactly 2 lines;
  - de high 640×480 ticks;
  - frame_start once per frame.
- pix_ce=1 every third clk: counters advance only on pix_ce, and the line period is 2400 clks.
- gameState=1, x1=100, y1=200, p1State=0, p1Left=0. Pixel (100,200) → 8'hE0. Pixel (130,210) → 8'h00 (face marker). Pixel (132,200) → 8'h49.
- p1health=3, p2health=15, gameState=1. Row 20: h=63 → 8'h1C, h=64 → background, h=384 → 8'h1C, h=383 → background.
- Change x1 from 100 to 300 mid-frame (vcount=240). The rest of that frame still draws the sprite at 100; the next frame draws it at 300.
- gameState=4 → every visible pixel 8'h03, blanking pixels 0. Assert rst at vcount=100: all outputs at reset values, counters restart at 0,0.
